mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Data-memory access stage between the EX/MEM pipeline register outputs and the MEM/WB register inputs of the 5-stage MIPS core.
- Converts load/store control from EX/MEM into a request/ready transaction on a variable-latency data bus. Handles byte and halfword lane alignment and load sign/zero extension.
- Drives a pipeline stall while a transaction is outstanding.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16: maximum cycles spent in BUSY before the access is abandoned with buserr.
- CNTW, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  synchronous, active-low reset.
- memtoreg  in  1  load in MEM (from EX/MEM).
- memwrite  in  1  store in MEM.
- aluout  in  32  effective byte address.
- writedata  in  32  store data (lane 0 aligned).
- memsize  in  2  access size: 00 byte, 01 half, 10 word.
- memunsigned  in  1  1 = zero-extend load, 0 = sign-extend.
- dready  in  1  bus completes the current request.
- drdata  in  32  bus read data, valid when dready=1.
- dreq  out  1  bus request (registered).
- dwe  out  1  write enable (registered).
- daddr  out  32  word-aligned address {aluout[31:2],2'b00} (registered).
- dbe  out  4  byte enables (registered).
- dwdata  out  32  lane-replicated store data (registered).
- stall  out  1  holds IF..MEM stages (combinational).
- readdata  out  32  extended load result to MEM/WB (registered).
- adel  out  1  misaligned-load pulse.
- ades  out  1  misaligned-store pulse.
- buserr  out  1  timeout pulse.

Behaviour:
- Reset (resetn=0 at a posedge):
  - state=IDLE.
  - dreq, dwe, dbe, adel, ades, buserr = 0.
  - daddr, dwdata, readdata = 0.
  - Counter = 0.
  - Applies from any state. A request in flight is abandoned and dreq is 0 from the next cycle.
- access = memtoreg | memwrite. memtoreg and memwrite are never both 1.
- Misalignment:
  - half with aluout[0]=1, or word with aluout[1:0]!=0.
  - Access is not issued and the state stays IDLE.
  - adel (load) or ades (store) is high for exactly one cycle at the next edge.
  - stall=0 for this access.
- States:
  - IDLE:
    - aligned access → BUSY.
    - Same edge: register dreq=1, dwe=memwrite, daddr, dbe, dwdata. Counter=0.
  - BUSY:
    - dreq held at 1; counter increments each cycle.
    - dready=1 → DONE. Same edge: dreq=0, and readdata = extended drdata for loads (readdata unchanged for stores).
    - If counter reaches TIMEOUT-1 without dready → DONE with dreq=0, readdata=0, buserr=1 for one cycle.
    - If dready and timeout coincide, dready wins and there is no buserr.
  - DONE: one cycle, stall=0 so the pipeline advances. Next state is IDLE unconditionally.
- stall = access & ~misaligned & (state != DONE).
  - A load/store therefore stalls at least 2 cycles: IDLE cycle, BUSY cycle(s), then released in DONE.
  - Minimum latency is 2 cycles from access seen to readdata valid (dready in the first BUSY cycle).
- Inputs are held stable by stall while in BUSY. The unit latches all request fields at IDLE→BUSY and does not re-sample inputs in BUSY.
- Byte enables:
  - byte: 1<<aluout[1:0].
  - half: aluout[1] ? 1100 : 0011.
  - word: 1111.
- Store data:
  - byte: writedata[7:0] replicated ×4.
  - half: writedata[15:0] replicated ×2.
  - word: unchanged.
- Load data:
  - byte: select drdata lane aluout[1:0].
  - half: lane aluout[1].
  - Extend to 32 bits per memunsigned. Word is passed through.
- memsize=11 is treated as word.
- Flag pulses (adel, ades, buserr) never overlap with dreq=1.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10;
  - state encodings S_IDLE, S_BUSY, S_DONE.
- One combinational sub-module, mem_lane_align, does the lane work:
  - inputs: size, addr[1:0], unsigned, wdata, rdata;
  - outputs: dbe, replicated wdata, extended rdata, misaligned.
- The FSM, counter and output registers stay in mem_access_unit.

Test Plan:
- Word load, addr 0x0000_1004, dready in the first BUSY cycle, drdata 0xDEADBEEF:
  - daddr 0x0000_1004, dbe 1111;
  - stall high 2 cycles, readdata 0xDEADBEEF in the DONE cycle.
- Signed byte load, addr 0x0000_2003, drdata 0x80FF_0011, memunsigned=0:
  - readdata 0xFFFF_FF80.
  - Repeat with memunsigned=1 → 0x0000_0080.
- Halfword store, addr 0x0000_3002, writedata 0x1234_ABCD:
  - dwe=1, dbe 1100, dwdata 0xABCD_ABCD, daddr 0x0000_3000.
- Word load at addr 0x0000_4002:
  - no dreq, adel=1 for one cycle, stall never asserted.
- dready never asserted, TIMEOUT=16:
  - dreq high exactly 16 cycles, then buserr pulse and readdata 0;
  - stall falls in DONE, state back in IDLE.
- resetn=0 for one edge during BUSY:
  - dreq=0, stall released (state IDLE), readdata=0 from the following cycle;
  - a subsequent aligned load completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access stage: access sizes and FSM states.
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data bus: byte enables, store replication,
// load lane select with sign/zero extension, and alignment check.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  dbe,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] rdata_sh;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rdata_sh = rdata >> {addr, 3'b000};
  assign rbyte    = rdata_sh[7:0];
  assign rhalf    = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    dbe        = 4'b1111;
    wdata_rep  = wdata;
    rdata_ext  = rdata;
    misaligned = 1'b0;
    case (size)
      MEM_BYTE: begin
        dbe       = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = is_unsigned ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      MEM_HALF: begin
        dbe        = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = is_unsigned ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
        misaligned = addr[0];
      end
      // MEM_WORD and the unused 2'b11 encoding both behave as word
      default: begin
        misaligned = (addr != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data access: turns EX/MEM load/store control into a req/ready
// bus transaction, stalls the pipeline while outstanding, flags faults.
//
// state  | meaning
// S_IDLE | no request outstanding; aligned access issues, misaligned one flags
// S_BUSY | dreq held, waiting for dready or the timeout
// S_DONE | one cycle with stall released so the pipeline advances
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        memtoreg,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  input  logic [1:0]  memsize,
  input  logic        memunsigned,
  input  logic        dready,
  input  logic [31:0] drdata,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [3:0]  dbe,
  output logic [31:0] dwdata,
  output logic        stall,
  output logic [31:0] readdata,
  output logic        adel,
  output logic        ades,
  output logic        buserr
);

  mem_state_t state, state_nxt;

  logic [CNTW-1:0] cnt;
  logic [1:0]      lat_size;
  logic [1:0]      lat_addr;
  logic            lat_uns;
  logic            lat_load;

  logic            access;
  logic            timeout;
  logic            in_idle;
  logic [1:0]      ln_size;
  logic [1:0]      ln_addr;
  logic            ln_uns;
  logic [3:0]      ln_dbe;
  logic [31:0]     ln_wdata;
  logic [31:0]     ln_rdata;
  logic            ln_mis;

  assign access  = memtoreg | memwrite;
  assign in_idle = (state == S_IDLE);
  assign timeout = (cnt == CNTW'(TIMEOUT - 1));

  // Outside IDLE the lane logic works from the fields latched at issue time
  assign ln_size = in_idle ? memsize     : lat_size;
  assign ln_addr = in_idle ? aluout[1:0] : lat_addr;
  assign ln_uns  = in_idle ? memunsigned : lat_uns;

  mem_lane_align u_lane (
    .size        (ln_size),
    .addr        (ln_addr),
    .is_unsigned (ln_uns),
    .wdata       (writedata),
    .rdata       (drdata),
    .dbe         (ln_dbe),
    .wdata_rep   (ln_wdata),
    .rdata_ext   (ln_rdata),
    .misaligned  (ln_mis)
  );

  assign stall = access & ~ln_mis & (state != S_DONE);

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (access && !ln_mis) state_nxt = S_BUSY;
      S_BUSY:  if (dready || timeout) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dreq     <= 1'b0;
      dwe      <= 1'b0;
      daddr    <= '0;
      dbe      <= '0;
      dwdata   <= '0;
      readdata <= '0;
      adel     <= 1'b0;
      ades     <= 1'b0;
      buserr   <= 1'b0;
      cnt      <= '0;
      lat_size <= '0;
      lat_addr <= '0;
      lat_uns  <= 1'b0;
      lat_load <= 1'b0;
    end else begin
      adel   <= 1'b0;
      ades   <= 1'b0;
      buserr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access && ln_mis) begin
            adel <= memtoreg;
            ades <= memwrite;
          end else if (access) begin
            dreq     <= 1'b1;
            dwe      <= memwrite;
            daddr    <= {aluout[31:2], 2'b00};
            dbe      <= ln_dbe;
            dwdata   <= ln_wdata;
            cnt      <= '0;
            lat_size <= memsize;
            lat_addr <= aluout[1:0];
            lat_uns  <= memunsigned;
            lat_load <= memtoreg;
          end
        end
        S_BUSY: begin
          cnt <= cnt + CNTW'(1);
          // dready takes priority over a coinciding timeout
          if (dready) begin
            dreq <= 1'b0;
            dwe  <= 1'b0;
            if (lat_load) readdata <= ln_rdata;
          end else if (timeout) begin
            dreq     <= 1'b0;
            dwe      <= 1'b0;
            readdata <= '0;
            buserr   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, timeout, reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        memtoreg, memwrite, memunsigned, dready;
  logic [31:0] aluout, writedata, drdata;
  logic [1:0]  memsize;
  logic        dreq, dwe, stall, adel, ades, buserr;
  logic [31:0] daddr, dwdata, readdata;
  logic [3:0]  dbe;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(16), .CNTW(5)) dut (
    .clk(clk), .resetn(resetn), .memtoreg(memtoreg), .memwrite(memwrite),
    .aluout(aluout), .writedata(writedata), .memsize(memsize),
    .memunsigned(memunsigned), .dready(dready), .drdata(drdata),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dbe(dbe), .dwdata(dwdata),
    .stall(stall), .readdata(readdata), .adel(adel), .ades(ades), .buserr(buserr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    memtoreg = 0; memwrite = 0; dready = 0;
  endtask

  initial begin
    int n;
    resetn = 0; memtoreg = 0; memwrite = 0; memunsigned = 0; dready = 0;
    aluout = 0; writedata = 0; drdata = 0; memsize = 2'b10;
    tick(); tick();
    resetn = 1;
    #1;
    chk("rst_dreq", 32'(dreq), 32'd0);
    chk("rst_dbe", 32'(dbe), 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // word load, dready in first BUSY cycle
    memtoreg = 1; aluout = 32'h0000_1004; memsize = 2'b10;
    #1 chk("wl_stall_idle", 32'(stall), 32'd1);
    tick();
    chk("wl_dreq", 32'(dreq), 32'd1);
    chk("wl_dwe", 32'(dwe), 32'd0);
    chk("wl_daddr", daddr, 32'h0000_1004);
    chk("wl_dbe", 32'(dbe), 32'hF);
    chk("wl_stall_busy", 32'(stall), 32'd1);
    dready = 1; drdata = 32'hDEAD_BEEF;
    tick();
    chk("wl_dreq_done", 32'(dreq), 32'd0);
    chk("wl_readdata", readdata, 32'hDEAD_BEEF);
    chk("wl_stall_done", 32'(stall), 32'd0);
    idle_inputs();
    tick();

    // signed byte load, lane 3
    memtoreg = 1; aluout = 32'h0000_2003; memsize = 2'b00; memunsigned = 0;
    tick();
    chk("sb_dbe", 32'(dbe), 32'h8);
    chk("sb_daddr", daddr, 32'h0000_2000);
    dready = 1; drdata = 32'h80FF_0011;
    tick();
    chk("sb_readdata", readdata, 32'hFFFF_FF80);
    idle_inputs(); tick();

    // unsigned byte load, same lane
    memtoreg = 1; memunsigned = 1;
    tick();
    dready = 1;
    tick();
    chk("ub_readdata", readdata, 32'h0000_0080);
    idle_inputs(); tick();

    // signed half load, upper half
    memtoreg = 1; aluout = 32'h0000_2002; memsize = 2'b01; memunsigned = 0;
    tick();
    chk("sh_dbe", 32'(dbe), 32'hC);
    dready = 1;
    tick();
    chk("sh_readdata", readdata, 32'hFFFF_80FF);
    idle_inputs(); tick();

    // halfword store
    memwrite = 1; aluout = 32'h0000_3002; memsize = 2'b01; writedata = 32'h1234_ABCD;
    tick();
    chk("hs_dwe", 32'(dwe), 32'd1);
    chk("hs_dbe", 32'(dbe), 32'hC);
    chk("hs_dwdata", dwdata, 32'hABCD_ABCD);
    chk("hs_daddr", daddr, 32'h0000_3000);
    dready = 1; drdata = 32'h5555_5555;
    tick();
    chk("hs_readdata_kept", readdata, 32'hFFFF_80FF);
    idle_inputs(); tick();

    // byte store lane 1
    memwrite = 1; aluout = 32'h0000_3001; memsize = 2'b00; writedata = 32'hAAAA_AA77;
    tick();
    chk("bs_dbe", 32'(dbe), 32'h2);
    chk("bs_dwdata", dwdata, 32'h7777_7777);
    dready = 1;
    tick();
    idle_inputs(); tick();

    // misaligned word load
    memtoreg = 1; aluout = 32'h0000_4002; memsize = 2'b10;
    #1 chk("ml_stall", 32'(stall), 32'd0);
    tick();
    chk("ml_adel", 32'(adel), 32'd1);
    chk("ml_dreq", 32'(dreq), 32'd0);
    chk("ml_ades", 32'(ades), 32'd0);
    idle_inputs();
    tick();
    chk("ml_adel_pulse", 32'(adel), 32'd0);

    // misaligned half store
    memwrite = 1; aluout = 32'h0000_5001; memsize = 2'b01;
    #1 chk("ms_stall", 32'(stall), 32'd0);
    tick();
    chk("ms_ades", 32'(ades), 32'd1);
    chk("ms_dreq", 32'(dreq), 32'd0);
    idle_inputs();
    tick();

    // timeout: dready never comes
    memtoreg = 1; aluout = 32'h0000_6000; memsize = 2'b10;
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!dreq) break;
      n++;
      tick();
    end
    chk("to_dreq_cycles", 32'(n), 32'd16);
    chk("to_buserr", 32'(buserr), 32'd1);
    chk("to_readdata", readdata, 32'd0);
    chk("to_stall_done", 32'(stall), 32'd0);
    idle_inputs();
    tick();
    chk("to_buserr_pulse", 32'(buserr), 32'd0);
    chk("to_idle_stall", 32'(stall), 32'd0);

    // dready coinciding with the timeout cycle wins
    memtoreg = 1; aluout = 32'h0000_7000; memsize = 2'b10;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("co_dreq_last", 32'(dreq), 32'd1);
    dready = 1; drdata = 32'hCAFE_F00D;
    tick();
    chk("co_buserr", 32'(buserr), 32'd0);
    chk("co_readdata", readdata, 32'hCAFE_F00D);
    idle_inputs(); tick();

    // reset during BUSY
    memtoreg = 1; aluout = 32'h0000_8000; memsize = 2'b10;
    tick();
    chk("rb_dreq_busy", 32'(dreq), 32'd1);
    resetn = 0; memtoreg = 0;
    tick();
    resetn = 1;
    #1;
    chk("rb_dreq", 32'(dreq), 32'd0);
    chk("rb_stall", 32'(stall), 32'd0);
    chk("rb_readdata", readdata, 32'd0);
    memtoreg = 1; aluout = 32'h0000_8004;
    tick();
    chk("rb2_daddr", daddr, 32'h0000_8004);
    dready = 1; drdata = 32'h1234_5678;
    tick();
    chk("rb2_readdata", readdata, 32'h1234_5678);
    idle_inputs(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
